// File: rtl/uart_rx_word_buffer.sv
// ============================================================================
// uart_rx_word_buffer
//
// Packs the byte stream coming out of the UART receiver into 32-bit
// little-endian words (first byte received lands in bits [7:0]) and queues
// the completed words in a first-word-fall-through FIFO that the core-side
// loader drains through a valid/ready handshake.
//
// Parameters:
//   DEPTH         FIFO depth in 32-bit words (power of two, >= 2)
//   BYTE_TIMEOUT  idle clocks after the last byte before a partial word is
//                 thrown away (>= 2); only meaningful with the macro below
//
// Optional feature macro:
//   UART_RX_WORD_TIMEOUT_EN  when defined, an inter-byte idle counter discards
//                            stale partial words and pulses timed_out; when
//                            undefined, partial words are held indefinitely
//                            and timed_out is tied low.
//
// Ports:
//   clk             system clock, everything on the rising edge
//   reset           asynchronous reset, active low (0 = in reset)
//   rx_data[7:0]    byte from the UART receiver, qualified by rx_ok
//   rx_ok           one-cycle strobe marking a new byte on rx_data
//   word_data[31:0] head-of-FIFO word, 0 while the FIFO is empty
//   word_valid      FIFO holds at least one word
//   word_ready      consumer takes word_data on this rising edge
//   count           number of words stored, 0..DEPTH
//   partial[1:0]    bytes currently held in the assembler, 0..3
//   overflow        sticky flag: a completed word was dropped on a full FIFO
//   clear_overflow  synchronous clear for overflow (a new drop wins)
//   timed_out       one-cycle pulse when a partial word is discarded
// ============================================================================
module uart_rx_word_buffer #(
    parameter int DEPTH        = 16,
    parameter int BYTE_TIMEOUT = 200000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ok,
    output logic [31:0]              word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               partial,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic                     timed_out
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(DEPTH);

    // Reject parameter values the pointer arithmetic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_word_buffer: DEPTH must be a power of two >= 2");
    end
    if (BYTE_TIMEOUT < 2) begin : g_bad_timeout
        $error("uart_rx_word_buffer: BYTE_TIMEOUT must be >= 2");
    end

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [23:0]   asm_reg;

    logic          fifo_full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;
    logic          expire;
    logic [31:0]   new_word;

    // ------------------------------------------------------------------------
    // Handshake and push/drop decisions
    // ------------------------------------------------------------------------
    assign fifo_full  = (count == DEPTH_CNT);
    assign word_valid = (count != '0);
    assign word_data  = word_valid ? mem[rd_ptr] : 32'd0;
    assign pop        = word_valid & word_ready;

    // The fourth byte completes the word straight from rx_data, so it can be
    // written into the FIFO on the same edge that accepts the byte.
    assign push_req   = rx_ok & (partial == 2'd3);
    assign new_word   = {rx_data, asm_reg};

    // A full FIFO still takes the word if the head leaves on the same edge.
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    // ------------------------------------------------------------------------
    // FIFO storage (not reset: count gates everything that is visible)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_word;
        end
    end

    // Pointers wrap naturally at DEPTH; the separate count removes any
    // full/empty ambiguity when the pointers are equal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky overflow; a drop on the same edge as a clear keeps it set
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Byte assembler: partial doubles as the byte-lane selector
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            partial <= 2'd0;
            asm_reg <= 24'd0;
        end else if (rx_ok) begin
            if (partial == 2'd3) begin
                partial <= 2'd0;
                asm_reg <= 24'd0;
            end else begin
                partial <= partial + 2'd1;
                case (partial)
                    2'd0:    asm_reg[7:0]   <= rx_data;
                    2'd1:    asm_reg[15:8]  <= rx_data;
                    2'd2:    asm_reg[23:16] <= rx_data;
                    default: asm_reg        <= asm_reg;
                endcase
            end
        end else if (expire) begin
            partial <= 2'd0;
            asm_reg <= 24'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Inter-byte timeout
    // ------------------------------------------------------------------------
`ifdef UART_RX_WORD_TIMEOUT_EN
    localparam int          TW           = $clog2(BYTE_TIMEOUT);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BYTE_TIMEOUT - 1);

    logic [TW-1:0] idle_cnt;

    // A byte arriving in the expiry cycle wins over the discard.
    assign expire = ~rx_ok & (partial != 2'd0) & (idle_cnt == TIMEOUT_LAST);

    // The counter only runs while a partial word is waiting; any byte, an
    // empty assembler or a discard parks it back at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            timed_out <= expire;
            if (rx_ok || (partial == 2'd0) || expire) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end
`else
    assign expire    = 1'b0;
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_word_buffer.sv
// ============================================================================
// tb_uart_rx_word_buffer
//
// Self-checking bench for uart_rx_word_buffer. The stimulus process drives one
// cycle at a time and keeps a behavioural model made of a byte queue (the
// assembler) and a word queue (the FIFO contents). The monitor samples the
// DUT on every falling edge, compares it against the model and pops the word
// queue whenever the consumer takes a word.
// ============================================================================
module tb_uart_rx_word_buffer;

    localparam int DEPTH        = 16;
    localparam int BYTE_TIMEOUT = 100;
    localparam int CW           = $clog2(DEPTH) + 1;
`ifdef UART_RX_WORD_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic          clk            = 1'b0;
    logic          reset          = 1'b0;
    logic [7:0]    rx_data        = 8'd0;
    logic          rx_ok          = 1'b0;
    logic [31:0]   word_data;
    logic          word_valid;
    logic          word_ready     = 1'b0;
    logic [CW-1:0] count;
    logic [1:0]    partial;
    logic          overflow;
    logic          clear_overflow = 1'b0;
    logic          timed_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [7:0]  exp_bytes[$];
    bit          exp_overflow    = 1'b0;
    bit          exp_timed_out   = 1'b0;
    int          cycle_n         = 0;
    int          last_byte_cycle = 0;

    // Observation helpers filled in by the monitor
    bit track_max = 1'b0;
    int max_count = 0;
    int to_pulses = 0;

    uart_rx_word_buffer #(
        .DEPTH        (DEPTH),
        .BYTE_TIMEOUT (BYTE_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_ok          (rx_ok),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .count          (count),
        .partial        (partial),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .timed_out      (timed_out)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one clock cycle of inputs, work out what the model says this
    // cycle does, then commit the model right after the rising edge.
    task automatic applyStimulus(input bit ok, input logic [7:0] data,
                                 input bit ready, input bit clr);
        logic [7:0]  nb[$];
        logic [31:0] w       = 32'd0;
        bit          do_push = 1'b0;
        bit          nxt_to  = 1'b0;
        bit          nxt_ovf;
        nb      = exp_bytes;
        nxt_ovf = exp_overflow;
        rx_ok          = ok;
        rx_data        = ok ? data : 8'($urandom);
        word_ready     = ready;
        clear_overflow = clr;
        if (clr) nxt_ovf = 1'b0;
        if (ok) begin
            nb.push_back(data);
            last_byte_cycle = cycle_n;
            if (nb.size() == 4) begin
                w = {nb[3], nb[2], nb[1], nb[0]};
                nb.delete();
                if (exp_q.size() < DEPTH || (ready && exp_q.size() != 0))
                    do_push = 1'b1;
                else
                    nxt_ovf = 1'b1;
            end
        end else if (TIMEOUT_EN && nb.size() != 0 &&
                     (cycle_n - last_byte_cycle) == BYTE_TIMEOUT) begin
            nb.delete();
            nxt_to = 1'b1;
        end
        @(posedge clk);
        #1;
        if (do_push) exp_q.push_back(w);
        exp_bytes     = nb;
        exp_overflow  = nxt_ovf;
        exp_timed_out = nxt_to;
        cycle_n++;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit ready);
        for (int b = 0; b < 4; b++)
            applyStimulus(1'b1, w[8*b +: 8], ready, 1'b0);
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 8'd0, ready, 1'b0);
    endtask

    // Monitor: compare every observable against the model mid-cycle, then
    // retire the head word if the consumer takes it on the coming edge.
    always @(negedge clk) begin
        checkOutput("count", 32'(count), 32'(exp_q.size()));
        checkOutput("word_valid", 32'(word_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            checkOutput("word_data", word_data, exp_q[0]);
        else
            checkOutput("word_data_empty", word_data, 32'd0);
        checkOutput("partial", 32'(partial), 32'(exp_bytes.size()));
        checkOutput("overflow", 32'(overflow), 32'(exp_overflow));
        checkOutput("timed_out", 32'(timed_out), 32'(exp_timed_out));
        if (timed_out === 1'b1) to_pulses++;
        if (!track_max) max_count = 0;
        else if (int'(count) > max_count) max_count = int'(count);
        if (reset && word_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end

    initial begin
        int pulses_before;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", 32'(word_valid), 32'd0);
        checkOutput("rst_data", word_data, 32'd0);
        checkOutput("rst_partial", 32'(partial), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_timed_out", 32'(timed_out), 32'd0);
        reset = 1'b1;
        idle(2, 1'b0);

        // Little-endian packing of one word
        $display("[TB] basic packing");
        applyStimulus(1'b1, 8'h78, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h56, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
        checkOutput("t1_data", word_data, 32'h12345678);
        checkOutput("t1_valid", 32'(word_valid), 32'd1);
        checkOutput("t1_count", 32'(count), 32'd1);
        checkOutput("t1_partial", 32'(partial), 32'd0);
        idle(3, 1'b1);

        // Fill past full, drain in order, then clear the sticky flag
        $display("[TB] overflow and drain");
        for (int i = 0; i < DEPTH + 1; i++) sendWord($urandom, 1'b0);
        checkOutput("t2_count_full", 32'(count), 32'(DEPTH));
        checkOutput("t2_overflow", 32'(overflow), 32'd1);
        idle(DEPTH + 2, 1'b1);
        checkOutput("t2_count_empty", 32'(count), 32'd0);
        checkOutput("t2_data_empty", word_data, 32'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkOutput("t2_overflow_clr", 32'(overflow), 32'd0);

        // Push and pop together on a full FIFO
        $display("[TB] push+pop on full");
        for (int i = 0; i < DEPTH; i++) sendWord($urandom, 1'b0);
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hD4, 1'b1, 1'b0);
        idle(1, 1'b0);
        checkOutput("t3_count", 32'(count), 32'(DEPTH));
        checkOutput("t3_overflow", 32'(overflow), 32'd0);
        idle(DEPTH + 2, 1'b1);

        // Inter-byte timeout on a two-byte partial word
        $display("[TB] inter-byte timeout");
        pulses_before = to_pulses;
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        idle(BYTE_TIMEOUT + 10, 1'b0);
`ifdef UART_RX_WORD_TIMEOUT_EN
        checkOutput("t4_pulses", 32'(to_pulses - pulses_before), 32'd1);
        checkOutput("t4_partial", 32'(partial), 32'd0);
        sendWord(32'hAABBCCDD, 1'b0);
        checkOutput("t4_word", word_data, 32'hAABBCCDD);
`else
        checkOutput("t4_pulses", 32'(to_pulses - pulses_before), 32'd0);
        checkOutput("t4_partial", 32'(partial), 32'd2);
        sendWord(32'hAABBCCDD, 1'b0);
        checkOutput("t4_word", word_data, 32'hCCDD2211);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
`endif
        idle(4, 1'b1);

        // Asynchronous reset with words queued and a partial word held
        $display("[TB] asynchronous reset");
        for (int i = 0; i < 3; i++) sendWord($urandom, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        exp_q.delete();
        exp_bytes.delete();
        exp_overflow  = 1'b0;
        exp_timed_out = 1'b0;
        #1;
        checkOutput("t5_count", 32'(count), 32'd0);
        checkOutput("t5_valid", 32'(word_valid), 32'd0);
        checkOutput("t5_data", word_data, 32'd0);
        checkOutput("t5_partial", 32'(partial), 32'd0);
        checkOutput("t5_overflow", 32'(overflow), 32'd0);
        checkOutput("t5_timed_out", 32'(timed_out), 32'd0);
        rx_ok   = 1'b1;
        rx_data = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rx_ok = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        sendWord(32'hCAFEF00D, 1'b0);
        idle(1, 1'b0);
        checkOutput("t5_count_after", 32'(count), 32'd1);
        checkOutput("t5_word_after", word_data, 32'hCAFEF00D);
        idle(2, 1'b1);

        // Streaming through pointer wrap with an eager consumer
        $display("[TB] streaming");
        track_max = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) sendWord($urandom, 1'b1);
        idle(2, 1'b1);
        checkOutput("t6_max_count_gt1", 32'(max_count > 1), 32'd0);
        checkOutput("t6_overflow", 32'(overflow), 32'd0);
        track_max = 1'b0;

        // Random traffic: a congested phase followed by a relaxed phase
        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++)
            applyStimulus(bit'($urandom_range(0, 9) != 0), 8'($urandom),
                          bit'($urandom_range(0, 19) == 0),
                          bit'($urandom_range(0, 63) == 0));
        for (int i = 0; i < 900; i++)
            applyStimulus(bit'($urandom_range(0, 1)), 8'($urandom),
                          bit'($urandom_range(0, 9) < 4),
                          bit'($urandom_range(0, 31) == 0));
        idle(DEPTH + 4, 1'b1);
        checkOutput("t7_drained", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
